fullsub_serial: RTL and testbench

//   Bit-serial subtractor computing out = in1 - in2 - bin over WIDTH clock cycles, LSB first.
//   It is the inverse-direction companion to the parallel 4-bit full adder and shares its
//   in1/in2/carry-style operand interface.
//   The start/busy/done handshake lets a datapath controller issue an operation and collect
//   the WIDTH-bit difference plus borrow-out.

---
 rtl/fullsub_serial_if.sv | 24 ++
 rtl/fullsub_serial.sv | 108 ++++++++++
 tb/tb_fullsub_serial.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fullsub_serial_if.sv
// Operand/result bundle between a datapath controller and the bit-serial subtractor.
// The controller drives the master side; the subtractor implements the slave side.
interface fullsub_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             bout;

  modport master (
    output start, in1, in2, bin,
    input  busy, done, out, bout
  );

  modport slave (
    input  start, in1, in2, bin,
    output busy, done, out, bout
  );
endinterface

// File: rtl/fullsub_serial.sv
// Bit-serial subtractor: out = in1 - in2 - bin (mod 2^WIDTH), one bit per cycle, LSB first.
// state | meaning
// IDLE  | waiting for start; result registers hold the last difference
// CALC  | shifting one difference bit per cycle, WIDTH cycles in total
// DONE  | one-cycle done pulse; start here restarts with no idle gap
module fullsub_serial #(
  parameter int WIDTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fullsub_serial_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             bout_q, bout_d;

  logic             diff_bit;
  logic             brw_next;
  logic [WIDTH-1:0] r_shift;
  logic             last_bit;

  // One full-subtractor cell applied to the current LSBs.
  assign diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign r_shift  = {diff_bit, r_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.in1;
          b_d     = bus.in2;
          brw_d   = bus.bin;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_next;
        r_d   = r_shift;
        cnt_d = cnt_q + CW'(1);
        // Publish only on the final bit so out/bout stay stable during a calculation.
        if (last_bit) begin
          out_d   = r_shift;
          bout_d  = brw_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_fullsub_serial.sv
// Directed bench for fullsub_serial: table of hand-computed differences plus
// multi-cycle sequences for ignored start, back-to-back restart and mid-operation reset.
module tb_fullsub_serial;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fullsub_serial_if #(.WIDTH(4)) bus ();

  fullsub_serial #(.WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in1;
    logic [3:0] in2;
    logic       bin;
    logic [3:0] exp_out;
    logic       exp_bout;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] prev_out;
  logic       prev_bout;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle at a time until done is seen or the budget runs out.
  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    bus.start = 1'b1;
    bus.in1   = v.in1;
    bus.in2   = v.in2;
    bus.bin   = v.bin;
    @(negedge clk);
    cyc = 1;
    bus.start = 1'b0;
    bus.in1   = ~v.in1;
    bus.in2   = ~v.in2;
    bus.bin   = ~v.bin;
    check($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
    @(negedge clk);
    cyc = 2;
    check($sformatf("v%0d_out_held", idx), 32'(bus.out), 32'(prev_out));
    check($sformatf("v%0d_bout_held", idx), 32'(bus.bout), 32'(prev_bout));
    wait_done(cyc);
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'd5);
    check($sformatf("v%0d_out", idx), 32'(bus.out), 32'(v.exp_out));
    check($sformatf("v%0d_bout", idx), 32'(bus.bout), 32'(v.exp_bout));
    check($sformatf("v%0d_done_busy", idx), 32'(bus.busy), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 32'd0);
    prev_out  = v.exp_out;
    prev_bout = v.exp_bout;
  endtask

  initial begin
    int cyc;
    int done_cnt;

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0};
    vecs[1] = '{4'b0010, 4'b0101, 1'b0, 4'b1101, 1'b1};
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[4] = '{4'b1011, 4'b0010, 1'b1, 4'b1000, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[6] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0};
    vecs[7] = '{4'b1000, 4'b1000, 1'b1, 4'b1111, 1'b1};
    vecs[8] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1};
    vecs[9] = '{4'b1100, 4'b0011, 1'b0, 4'b1001, 1'b0};

    bus.start = 1'b0;
    bus.in1   = 4'b0;
    bus.in2   = 4'b0;
    bus.bin   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0;
    prev_out  = 4'b0;
    prev_bout = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // start with different operands two cycles into CALC must be ignored
    bus.start = 1'b1; bus.in1 = 4'b0101; bus.in2 = 4'b0011; bus.bin = 1'b0;
    @(negedge clk); cyc = 1;
    bus.start = 1'b0;
    @(negedge clk); cyc = 2;
    bus.start = 1'b1; bus.in1 = 4'b0000; bus.in2 = 4'b0000; bus.bin = 1'b1;
    @(negedge clk); cyc = 3;
    bus.start = 1'b0;
    wait_done(cyc);
    check("ign_latency", 32'(cyc), 32'd5);
    check("ign_out", 32'(bus.out), 32'b0010);
    check("ign_bout", 32'(bus.bout), 32'd0);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("ign_single_done", 32'(done_cnt), 32'd0);
    check("ign_idle_busy", 32'(bus.busy), 32'd0);

    // start held through DONE restarts immediately with new operands
    bus.start = 1'b1; bus.in1 = 4'b1011; bus.in2 = 4'b0010; bus.bin = 1'b1;
    cyc = 0;
    wait_done(cyc);
    check("b2b_a_latency", 32'(cyc), 32'd5);
    check("b2b_a_out", 32'(bus.out), 32'b1000);
    bus.in1 = 4'b0010; bus.in2 = 4'b0101; bus.bin = 1'b0;
    @(negedge clk); cyc = 1;
    check("b2b_no_gap_busy", 32'(bus.busy), 32'd1);
    check("b2b_no_gap_done", 32'(bus.done), 32'd0);
    check("b2b_a_out_held", 32'(bus.out), 32'b1000);
    bus.start = 1'b0;
    wait_done(cyc);
    check("b2b_b_latency", 32'(cyc), 32'd5);
    check("b2b_b_out", 32'(bus.out), 32'b1101);
    check("b2b_b_bout", 32'(bus.bout), 32'd1);
    @(negedge clk);

    // reset during CALC aborts and clears the result
    bus.start = 1'b1; bus.in1 = 4'b1111; bus.in2 = 4'b0000; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    check("mid_rst_bout", 32'(bus.bout), 32'd0);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_out_later", 32'(bus.out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
